inst_fetch_seq: RTL and testbench

Parametrised program-counter and sequencing unit, the next generation of the processor's instruction fetch block.
- Supports multiple programs selected at Start, each with its own base address.
- Supports conditional relative branches against ALU flags, plus unconditional absolute jumps.
- Supports call/return through an internal return-address stack, a stall hold, and a halt/done handshake to the testbench.
- Sits between decode/ALU flags and the instruction ROM address port.

---
 rtl/inst_fetch_seq_pkg.sv | 34 +++
 rtl/inst_fetch_seq_if.sv | 37 +++
 rtl/inst_fetch_seq_ras_stack.sv | 51 +++++
 rtl/inst_fetch_seq.sv | 107 ++++++++++
 tb/tb_inst_fetch_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer:
// FSM states, branch-condition encodings and the default program bases.
package if_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_EQ     = 2'd1;
  localparam logic [1:0] COND_LT     = 2'd2;
  localparam logic [1:0] COND_GE     = 2'd3;

  localparam int DEF_PC_W      = 10;
  localparam int DEF_NUM_PROGS = 3;

  // Packed so that entry i is PROG_BASE[i]; index 0 is the rightmost element.
  localparam logic [DEF_NUM_PROGS-1:0][DEF_PC_W-1:0] DEF_PROG_BASE =
    {10'd512, 10'd256, 10'd0};

  function automatic logic cond_true(input logic [1:0] sel, input logic eq, input logic lt);
    logic r;
    case (sel)
      COND_EQ: r = eq;
      COND_LT: r = lt;
      COND_GE: r = ~lt;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_seq_if.sv
// Control/flag inputs and PC/status outputs of the fetch sequencer.
// Handshake: Done is a level held high while halted; the controller acknowledges
// by raising Start, and Done drops on the first edge that samples Start.
interface inst_fetch_seq_if #(
  parameter int PC_W      = 10,
  parameter int NUM_PROGS = 3
);
  localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic             Start;
  logic [SEL_W-1:0] ProgSel;
  logic             Stall;
  logic             Halt;
  logic             BranchAbs;
  logic             BranchRelEn;
  logic [1:0]       CondSel;
  logic             ALU_equals;
  logic             ALU_lt;
  logic             Call;
  logic             Ret;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Done;
  logic             RasErr;

  modport master (
    output Start, ProgSel, Stall, Halt, BranchAbs, BranchRelEn, CondSel,
           ALU_equals, ALU_lt, Call, Ret, Target,
    input  ProgCtr, Done, RasErr
  );

  modport slave (
    input  Start, ProgSel, Stall, Halt, BranchAbs, BranchRelEn, CondSel,
           ALU_equals, ALU_lt, Call, Ret, Target,
    output ProgCtr, Done, RasErr
  );
endinterface

// File: rtl/inst_fetch_seq_ras_stack.sv
// Circular return-address LIFO: pushing when full overwrites the oldest entry,
// popping when empty leaves the stack untouched; both report a one-cycle pulse.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW:0]   cnt;
  logic          full;

  assign full      = (cnt == (PW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign top       = mem[wp - PW'(1)];
  assign overflow  = push & ~pop & full;
  assign underflow = pop & empty;

  // Pop has priority when both are requested.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp  <= '0;
      cnt <= '0;
    end else if (pop) begin
      if (!empty) begin
        wp  <= wp - PW'(1);
        cnt <= cnt - (PW+1)'(1);
      end
    end else if (push) begin
      wp <= wp + PW'(1);
      if (!full) cnt <= cnt + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop && !rst && !clear) mem[wp] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_seq.sv
// Program counter and sequencing FSM: program launch, relative/absolute
// branches, call/return through ras_stack, stall and halt.
module inst_fetch_seq
  import if_seq_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int RAS_DEPTH = 4,
  parameter int NUM_PROGS = 3,
  parameter logic [NUM_PROGS-1:0][PC_W-1:0] PROG_BASE = DEF_PROG_BASE
) (
  input  logic               Clk,
  input  logic               Reset,
  inst_fetch_seq_if.slave    bus,
  output state_t             dbg_state
);
  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, base_pc;
  logic            start_q;
  logic            ras_err;
  logic            push, pop, clear;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_ovf, ras_unf;

  assign pc_inc = pc + PC_W'(1);

  // Out-of-range ProgSel falls back to address 0.
  always_comb begin
    base_pc = '0;
    for (int i = 0; i < NUM_PROGS; i++)
      if (int'(bus.ProgSel) == i) base_pc = PROG_BASE[i];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      start_q <= bus.Start;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    if (bus.Start) begin
      state_n = IDLE;
      pc_n    = base_pc;
      clear   = 1'b1;
    end else begin
      case (state)
        // Leave IDLE only on the cycle Start falls; PC already sits at base.
        IDLE: if (start_q) state_n = RUN;
        RUN: begin
          if (bus.Stall) begin
            pc_n = pc;
          end else if (bus.Halt) begin
            state_n = HALTED;
          end else if (bus.Ret) begin
            pop  = 1'b1;
            pc_n = ras_empty ? pc_inc : ras_top;
          end else if (bus.Call) begin
            push = 1'b1;
            pc_n = bus.Target;
          end else if (bus.BranchAbs) begin
            pc_n = bus.Target;
          end else if (bus.BranchRelEn && cond_true(bus.CondSel, bus.ALU_equals, bus.ALU_lt)) begin
            pc_n = pc + bus.Target;
          end else begin
            pc_n = pc_inc;
          end
        end
        HALTED:  pc_n = pc;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || bus.Start) ras_err <= 1'b0;
    else if (ras_ovf || ras_unf) ras_err <= 1'b1;
  end

  ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk       (Clk),
    .rst       (Reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  assign bus.ProgCtr = pc;
  assign bus.Done    = (state == HALTED);
  assign bus.RasErr  = ras_err;
  assign dbg_state   = state;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: the driver queues hand-computed
// {state, Done, RasErr, ProgCtr} per edge; a negedge monitor pops and compares.
module tb_inst_fetch_seq;
  import if_seq_pkg::*;

  localparam int W = 14;

  logic   Clk = 1'b0;
  logic   Reset;
  state_t dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  inst_fetch_seq_if #(.PC_W(10), .NUM_PROGS(3)) bus ();

  inst_fetch_seq #(.PC_W(10), .RAS_DEPTH(4), .NUM_PROGS(3)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Driver tasks
  task automatic clear_ctl();
    bus.Start       = 1'b0;
    bus.Stall       = 1'b0;
    bus.Halt        = 1'b0;
    bus.BranchAbs   = 1'b0;
    bus.BranchRelEn = 1'b0;
    bus.CondSel     = COND_ALWAYS;
    bus.ALU_equals  = 1'b0;
    bus.ALU_lt      = 1'b0;
    bus.Call        = 1'b0;
    bus.Ret         = 1'b0;
    bus.Target      = '0;
  endtask

  task automatic tick(input state_t st, input logic d, input logic e,
                      input logic [9:0] pc, input string nm);
    @(posedge Clk);
    #1;
    exp_q.push_back({st, d, e, pc});
    name_q.push_back(nm);
  endtask

  task automatic run(input logic [9:0] pc, input logic e, input string nm);
    tick(RUN, 1'b0, e, pc, nm);
  endtask

  task automatic jump(input logic [9:0] t, input logic e);
    clear_ctl();
    bus.BranchAbs = 1'b1;
    bus.Target    = t;
    run(t, e, "abs_jump");
    clear_ctl();
  endtask

  task automatic rel(input logic [1:0] cs, input logic eq, input logic lt,
                     input logic [9:0] t, input logic [9:0] exp_pc, input string nm);
    clear_ctl();
    bus.BranchRelEn = 1'b1;
    bus.CondSel     = cs;
    bus.ALU_equals  = eq;
    bus.ALU_lt      = lt;
    bus.Target      = t;
    run(exp_pc, 1'b0, nm);
    clear_ctl();
  endtask

  task automatic call(input logic [9:0] t, input logic e, input string nm);
    clear_ctl();
    bus.Call   = 1'b1;
    bus.Target = t;
    run(t, e, nm);
    clear_ctl();
  endtask

  task automatic ret(input logic [9:0] exp_pc, input logic e, input string nm);
    clear_ctl();
    bus.Ret = 1'b1;
    run(exp_pc, e, nm);
    clear_ctl();
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    logic [W-1:0] e_v, a_v;
    string        nm;
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      nm  = name_q.pop_front();
      a_v = {dbg_state, bus.Done, bus.RasErr, bus.ProgCtr};
      n_checks++;
      if (a_v === e_v) n_pass++;
      else $display("FAIL %s: got state=%0d done=%b err=%b pc=%0d, want state=%0d done=%b err=%b pc=%0d",
                    nm, a_v[13:12], a_v[11], a_v[10], a_v[9:0],
                    e_v[13:12], e_v[11], e_v[10], e_v[9:0]);
    end
  end

  // Stimulus
  initial begin
    clear_ctl();
    bus.ProgSel = '0;
    Reset = 1'b1;
    tick(IDLE, 1'b0, 1'b0, 10'd0, "reset");
    tick(IDLE, 1'b0, 1'b0, 10'd0, "reset_hold");
    Reset = 1'b0;
    tick(IDLE, 1'b0, 1'b0, 10'd0, "idle_no_start");

    bus.Start = 1'b1;
    bus.ProgSel = 2'd1;
    repeat (3) tick(IDLE, 1'b0, 1'b0, 10'd256, "start_hold");
    bus.Start = 1'b0;
    run(10'd256, 1'b0, "run_base");
    run(10'd257, 1'b0, "inc_1");
    run(10'd258, 1'b0, "inc_2");

    jump(10'd20, 1'b0);
    rel(COND_EQ, 1'b1, 1'b0, 10'h3FC, 10'd16, "rel_eq_taken");
    jump(10'd20, 1'b0);
    rel(COND_EQ, 1'b0, 1'b0, 10'h3FC, 10'd21, "rel_eq_not");
    rel(COND_LT, 1'b0, 1'b1, 10'd5, 10'd26, "rel_lt_taken");
    rel(COND_GE, 1'b0, 1'b1, 10'd5, 10'd27, "rel_ge_not");
    rel(COND_GE, 1'b0, 1'b0, 10'd5, 10'd32, "rel_ge_taken");
    rel(COND_ALWAYS, 1'b0, 1'b0, 10'd3, 10'd35, "rel_always");

    jump(10'd40, 1'b0);
    call(10'd100, 1'b0, "call_1");
    run(10'd101, 1'b0, "sub_inc_1");
    run(10'd102, 1'b0, "sub_inc_2");
    ret(10'd41, 1'b0, "ret_1");

    call(10'd200, 1'b0, "nest_1");
    call(10'd300, 1'b0, "nest_2");
    call(10'd400, 1'b0, "nest_3");
    call(10'd500, 1'b0, "nest_4_full");
    call(10'd600, 1'b1, "nest_5_overflow");
    ret(10'd501, 1'b1, "unwind_1");
    ret(10'd401, 1'b1, "unwind_2");
    ret(10'd301, 1'b1, "unwind_3");
    ret(10'd201, 1'b1, "unwind_4");
    ret(10'd202, 1'b1, "unwind_underflow");

    clear_ctl();
    bus.Call = 1'b1;
    bus.Ret = 1'b1;
    bus.Target = 10'd700;
    run(10'd203, 1'b1, "call_ret_ret_wins");

    jump(10'd1023, 1'b1);
    run(10'd0, 1'b1, "pc_wrap");
    bus.Stall = 1'b1;
    bus.BranchAbs = 1'b1;
    bus.Target = 10'd5;
    run(10'd0, 1'b1, "stall_abs");
    clear_ctl();
    bus.Stall = 1'b1;
    bus.Halt = 1'b1;
    run(10'd0, 1'b1, "stall_halt");
    clear_ctl();
    run(10'd1, 1'b1, "after_stall");

    jump(10'd77, 1'b1);
    bus.Halt = 1'b1;
    tick(HALTED, 1'b1, 1'b1, 10'd77, "halt");
    clear_ctl();
    bus.BranchAbs = 1'b1;
    bus.Target = 10'd5;
    repeat (10) tick(HALTED, 1'b1, 1'b1, 10'd77, "halted_hold");

    clear_ctl();
    bus.Start = 1'b1;
    bus.ProgSel = 2'd2;
    tick(IDLE, 1'b0, 1'b0, 10'd512, "restart_prog2");
    bus.Start = 1'b0;
    run(10'd512, 1'b0, "prog2_base");
    run(10'd513, 1'b0, "prog2_inc");

    call(10'd600, 1'b0, "call_before_start");
    bus.Start = 1'b1;
    bus.ProgSel = 2'd0;
    tick(IDLE, 1'b0, 1'b0, 10'd0, "start_in_run");
    bus.Start = 1'b0;
    run(10'd0, 1'b0, "prog0_base");
    ret(10'd1, 1'b1, "ret_stack_cleared");
    run(10'd2, 1'b1, "err_sticky");

    Reset = 1'b1;
    tick(IDLE, 1'b0, 1'b0, 10'd0, "reset_mid");
    Reset = 1'b0;
    tick(IDLE, 1'b0, 1'b0, 10'd0, "idle_after_reset");

    @(negedge Clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
